// File: rtl/dl_share_arbiter.sv
// dl_share_arbiter: round-robin arbiter and write sequencer for one shared
// DW-bit register. Grants a requester, captures its write data, holds the
// grant for HOLD settle cycles, then pulses done.
// Optional macro DL_ARB_FIXED_PRIO_EN: lowest-index request always wins and
// the round-robin pointer is removed. Timing is identical in both modes.
module dl_share_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int HOLD = 2,
    localparam int OW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [OW-1:0]      owner,
    output logic               le,
    output logic [DW-1:0]      q,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_HOLD, S_DONE} state_t;

    // Last settle-counter value before moving on; unused when HOLD == 0.
    localparam logic [3:0] HOLD_LAST = 4'((HOLD > 0) ? HOLD - 1 : 0);

    state_t          state;
    state_t          state_next;
    logic [3:0]      hold_cnt;
    logic [OW-1:0]   win;

`ifdef DL_ARB_FIXED_PRIO_EN
    // Lowest-index set request wins.
    function automatic logic [OW-1:0] pick_winner(input logic [NREQ-1:0] r);
        logic [OW-1:0] w;
        logic          found;
        w     = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && r[i]) begin
                w     = OW'(i);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign win = pick_winner(req);
`else
    logic [OW-1:0] ptr;

    // First set request scanning upward from the pointer, wrapping modulo NREQ.
    function automatic logic [OW-1:0] pick_winner(input logic [NREQ-1:0] r,
                                                  input logic [OW-1:0]   p);
        logic [OW-1:0] w;
        logic          found;
        int            idx;
        w     = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(p) + i) % NREQ;
            if (!found && r[idx]) begin
                w     = OW'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign win = pick_winner(req, ptr);
`endif

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state and decoded control outputs.
    always_comb begin
        state_next = state;
        le         = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (|req) state_next = S_GRANT;
            end
            S_GRANT: begin
                le         = 1'b1;
                state_next = (HOLD == 0) ? S_DONE : S_HOLD;
            end
            S_HOLD: begin
                if (hold_cnt == HOLD_LAST) state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Grant, owner, captured data, settle counter and priority pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt      <= '0;
            owner    <= '0;
            q        <= '0;
            hold_cnt <= '0;
`ifndef DL_ARB_FIXED_PRIO_EN
            ptr      <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    hold_cnt <= '0;
                    if (|req) begin
                        gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << win;
                        owner <= win;
                    end
                end
                S_GRANT: begin
                    q <= wdata[owner*DW +: DW];
                    if (state_next == S_DONE) gnt <= '0;
                end
                S_HOLD: begin
                    hold_cnt <= hold_cnt + 4'd1;
                    if (state_next == S_DONE) gnt <= '0;
                end
                S_DONE: begin
`ifndef DL_ARB_FIXED_PRIO_EN
                    // Winner drops to lowest priority for the next round.
                    ptr <= (owner == OW'(NREQ - 1)) ? '0 : owner + 1'b1;
`endif
                end
                default: gnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dl_share_arbiter.sv
// Self-checking bench for dl_share_arbiter: directed phases from the test
// plan followed by randomized requests/data/resets, checked by a
// transaction-level reference model and a scoreboard monitor.
module tb_dl_share_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int HOLD = 2;
    localparam int OW   = 2;

    logic               clk;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    gnt;
    logic [OW-1:0]      owner;
    logic               le;
    logic [DW-1:0]      q;
    logic               busy;
    logic               done;

    dl_share_arbiter #(.NREQ(NREQ), .DW(DW), .HOLD(HOLD)) dut (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata), .gnt(gnt),
        .owner(owner), .le(le), .q(q), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endfunction

    typedef struct {
        int            w;
        logic [DW-1:0] d;
        int            le_e;
        int            done_e;
    } txn_t;

    txn_t exp_q[$];

    // Reference model state (transaction level, edge-numbered).
    int   edge_cnt = 0;
    logic rst_q    = 1'b0;
    int   m_ptr    = 0;
    int   m_free   = 0;
    bit   m_pend   = 0;
    int   m_pw     = 0;
    int   m_cap_e  = 0;
    int   m_bfrom  = -1;
    int   m_bto    = -1;

    // Model: at each edge decide whether a new transaction starts and what it captures.
    always @(posedge clk) begin
        txn_t t;
        int   w;
        edge_cnt++;
        rst_q = rst;
        if (rst) begin
            exp_q.delete();
            m_ptr   = 0;
            m_free  = edge_cnt + 1;
            m_pend  = 0;
            m_bfrom = -1;
            m_bto   = -1;
        end else begin
            if (m_pend && edge_cnt == m_cap_e) begin
                t.w      = m_pw;
                t.d      = wdata[m_pw*DW +: DW];
                t.le_e   = m_cap_e - 1;
                t.done_e = m_cap_e + HOLD;
                exp_q.push_back(t);
                m_pend = 0;
            end
            if (edge_cnt >= m_free && req != 0) begin
                w = -1;
`ifdef DL_ARB_FIXED_PRIO_EN
                for (int k = NREQ - 1; k >= 0; k--)
                    if (req[k]) w = k;
`else
                for (int k = 0; k < NREQ; k++)
                    if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
                m_ptr = (w + 1) % NREQ;
`endif
                m_pend  = 1;
                m_pw    = w;
                m_cap_e = edge_cnt + 1;
                m_free  = edge_cnt + 3 + HOLD;
                m_bfrom = edge_cnt;
                m_bto   = edge_cnt + 1 + HOLD;
            end
        end
    end

    // Monitor state
    int              gnt_cycles = 0;
    bit              le_seen    = 0;
    logic [NREQ-1:0] le_gnt;
    logic [OW-1:0]   le_owner;
    int              le_e;

    // Monitor: per-cycle control checks, scoreboard pop on every done pulse.
    always @(negedge clk) begin
        txn_t            t;
        logic [NREQ-1:0] oh;
        if (edge_cnt > 0) begin
            if (rst_q) begin
                chk("rst_gnt", gnt, 0);
                chk("rst_le", le, 0);
                chk("rst_q", q, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                gnt_cycles = 0;
                le_seen    = 0;
            end else begin
                chk("gnt_onehot", ($countones(gnt) <= 1), 1);
                chk("busy", busy, (edge_cnt >= m_bfrom && edge_cnt <= m_bto));
                chk("le", le, (edge_cnt == m_bfrom));
                chk("done", done, (edge_cnt == m_bto));
                if (!busy) chk("idle_gnt", gnt, 0);
                if (gnt != 0) gnt_cycles++;
                if (le) begin
                    le_seen  = 1;
                    le_gnt   = gnt;
                    le_owner = owner;
                    le_e     = edge_cnt;
                end
                if (done) begin
                    chk("done_gnt", gnt, 0);
                    if (exp_q.size() == 0) begin
                        chk("done_expected", 0, 1);
                    end else begin
                        t  = exp_q.pop_front();
                        oh = '0;
                        oh[t.w] = 1'b1;
                        chk("le_seen", le_seen, 1);
                        chk("le_edge", le_e, t.le_e);
                        chk("grant", le_gnt, oh);
                        chk("owner", le_owner, t.w);
                        chk("owner_hold", owner, t.w);
                        chk("q", q, t.d);
                        chk("done_edge", edge_cnt, t.done_e);
                        chk("gnt_len", gnt_cycles, 1 + HOLD);
                    end
                    gnt_cycles = 0;
                    le_seen    = 0;
                end
            end
        end
    end

    task automatic step(int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst   = 1'b1;
        req   = 4'b1111;
        wdata = 32'h0;
        step(2);
        rst = 1'b0;
        step(1);
        req = 4'b0000;
        step(6);

        // Single request on requester 2
        wdata = 32'h00A5_0000;
        req   = 4'b0100;
        step(1);
        req = 4'b0000;
        step(6);

        // Round-robin with all requesting
        wdata = 32'h4433_2211;
        req   = 4'b1111;
        step(22);
        req = 4'b0000;
        step(8);

        // One-cycle request that drops
        wdata = 32'h0000_5A00;
        req   = 4'b0010;
        step(1);
        req = 4'b0000;
        step(8);

        // Reset during the second HOLD cycle, then requester 3
        req = 4'b0001;
        step(1);
        req = 4'b0000;
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        req = 4'b1000;
        step(1);
        req = 4'b0000;
        step(8);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 2500; n++) begin
            req = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) wdata[i*DW +: DW] = DW'($urandom);
            rst = ($urandom_range(0, 299) == 0);
            step(1);
        end

        rst = 1'b0;
        req = '0;
        step(12);
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dl_share_arbiter.md
Name: dl_share_arbiter

Overview:
- Round-robin arbiter and write sequencer for one shared DW-bit storage register. The register is built from the team's D-latch/flip-flop cells.
- NREQ requesters compete for write access. The block grants one requester, captures its data, holds the grant for a settle window, then signals done.
- Sits between requester logic and the shared register. Drives the register's enable (le) and presents the stored value on q.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 8, data width of the shared register
- HOLD, 2, settle cycles after capture with grant still held (0..15; 0 = no HOLD state)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  NREQ  level request, bit i = requester i
- wdata  input  NREQ*DW  packed write data, slice i = bits [i*DW +: DW]
- gnt  output  NREQ  one-hot grant, registered
- owner  output  max(1,$clog2(NREQ))  index of the current/last granted requester
- le  output  1  capture enable to the shared register, 1-cycle pulse
- q  output  DW  shared register contents
- busy  output  1  high in any state other than IDLE
- done  output  1  1-cycle pulse, transaction complete

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; gnt=0, owner=0, le=0, q=0, busy=0, done=0, rr pointer=0. Reset has priority over everything, including mid-transaction; an aborted transaction produces no done.
- States: IDLE -> GRANT -> HOLD (HOLD cycles; skipped when HOLD=0) -> DONE -> IDLE.
- IDLE:
  - req is sampled only in IDLE. If req!=0, pick the winner: the first set bit scanning from the pointer upward, wrapping modulo NREQ.
  - Next cycle: GRANT, gnt=onehot(winner), owner=winner.
  - If req==0, stay in IDLE.
- GRANT (1 cycle): le=1, busy=1. At the end of the cycle q <= wdata slice[owner]. So q updates 2 cycles after req is sampled.
- HOLD: gnt held, le=0; a counter runs HOLD cycles, then the state moves to DONE.
- DONE (1 cycle): gnt=0, done=1, busy=1. Pointer <= (owner+1) mod NREQ, giving the winner lowest priority next round.
- Per-transaction timing:
  - gnt is high for 1+HOLD cycles.
  - Transaction length: 1 (IDLE arbitration) + 1 + HOLD + 1 cycles.
  - Back-to-back period: 3+HOLD cycles (5 with defaults).
- Boundary conditions:
  - req changes after sampling (drop or new bits): ignored until the next IDLE. The current transaction always completes.
  - wdata changes after the GRANT cycle: no effect on q.
  - Single requester holding req continuously: re-granted every 3+HOLD cycles.
  - Pointer wrap: pointer=NREQ-1 scans NREQ-1, 0, 1, ...
  - gnt is never multi-hot. gnt and le are never asserted in IDLE or DONE.
- owner and q keep their last values between transactions.

Optional Feature:
- Macro: DL_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest-index set req bit always wins, and the pointer is not used or updated.
- Undefined: round-robin as above.
- Timing and all other behaviour are identical in both modes.

Test Plan:
- Reset: rst=1 for 2 cycles with req=4'b1111 -> gnt=0, le=0, q=8'h00, busy=0, done=0 throughout and on the first cycle after release; first grant 2'b?0 -> gnt=4'b0001.
- Single request: req=4'b0100, slice2=8'hA5 -> gnt=4'b0100 for 3 cycles, le=1 in the first of them, q=8'hA5 from the next cycle, then done=1 for 1 cycle with gnt=0, busy falls the cycle after.
- Round-robin: req=4'b1111 held, slices 8'h11/22/33/44 -> gnt sequence 0001, 0010, 0100, 1000, 0001, each grant starting 5 cycles after the previous; q follows 11, 22, 33, 44.
- Request drop: req=4'b0010 for one cycle only, slice1=8'h5A -> the full transaction completes, q=8'h5A, one done pulse, no second grant.
- Reset mid-HOLD: rst=1 during the 2nd HOLD cycle -> next cycle gnt=0, q=8'h00, done never pulses; after release req=4'b1000 -> owner=3.
- With DL_ARB_FIXED_PRIO_EN defined: req=4'b1111 held -> every grant is 4'b0001; req=4'b1010 -> every grant is 4'b0010.
